// File: rtl/div_arbiter_if.sv
// div_arbiter_if: request/grant/result bundle between the two division clients and div_arbiter.
interface div_arbiter_if #(
    parameter int NUM_W = 29,
    parameter int DEN_W = 17,
    parameter int Q_W   = 12
);
    logic             req0;
    logic [NUM_W-1:0] num0;
    logic [DEN_W-1:0] den0;
    logic             req1;
    logic [NUM_W-1:0] num1;
    logic [DEN_W-1:0] den1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [Q_W-1:0]   quotient;
    logic             sat;
    logic             dz;
    logic             busy;
    modport master (
        output req0, num0, den0, req1, num1, den1,
        input  gnt0, gnt1, done0, done1, quotient, sat, dz, busy
    );
    modport slave (
        input  req0, num0, den0, req1, num1, den1,
        output gnt0, gnt1, done0, done1, quotient, sat, dz, busy
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: two-client arbiter around one restoring divider, one quotient bit per clock, saturated result.
// Define DIV_ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise requester 0 wins every tie.
module div_arbiter #(
    parameter int NUM_W = 29,
    parameter int DEN_W = 17,
    parameter int Q_W   = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    div_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_W);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           r_state, w_state_nxt;
    logic [NUM_W-1:0] r_num;
    logic [DEN_W-1:0] r_den;
    logic [DEN_W:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner, r_dz, r_gnt0, r_gnt1, r_done0, r_done1, r_sat, r_dz_o, r_busy;
    logic [Q_W-1:0]   r_quotient;
    logic             w_start, w_win, w_ge, w_sat;
    logic [NUM_W-1:0] w_num_sel;
    logic [DEN_W-1:0] w_den_sel;
    logic [DEN_W:0]   w_rem_sh;
`ifdef DIV_ARB_ROUND_ROBIN_EN
    logic r_last;
    assign w_win = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_last <= 1'b1;
        else if (w_start) r_last <= w_win;
    end
`else
    assign w_win = ~bus.req0;
`endif
    assign w_num_sel = w_win ? bus.num1 : bus.num0;
    assign w_den_sel = w_win ? bus.den1 : bus.den0;
    // Quotient bits shift into the bottom of r_num as numerator bits leave the top.
    assign w_rem_sh  = {r_rem[DEN_W-1:0], r_num[NUM_W-1]};
    assign w_ge      = w_rem_sh >= {1'b0, r_den};
    assign w_sat     = r_dz | (|r_num[NUM_W-1:Q_W]);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                w_start     = bus.req0 | bus.req1;
                w_state_nxt = !w_start ? IDLE : (w_den_sel == '0) ? DONE : CALC;
            end
            CALC:    w_state_nxt = (r_cnt == '0) ? DONE : CALC;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num      <= '0;
            r_den      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_dz       <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_quotient <= '0;
            r_sat      <= 1'b0;
            r_dz_o     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_gnt0  <= w_start & ~w_win;
            r_gnt1  <= w_start & w_win;
            r_done0 <= (r_state == DONE) & ~r_owner;
            r_done1 <= (r_state == DONE) & r_owner;
            if (w_start) begin
                r_owner <= w_win;
                r_num   <= w_num_sel;
                r_den   <= w_den_sel;
                r_rem   <= '0;
                r_cnt   <= CNT_W'(NUM_W - 1);
                r_dz    <= (w_den_sel == '0);
                r_busy  <= 1'b1;
            end else if (r_state == CALC) begin
                r_rem <= w_ge ? w_rem_sh - {1'b0, r_den} : w_rem_sh;
                r_num <= {r_num[NUM_W-2:0], w_ge};
                r_cnt <= r_cnt - 1'b1;
            end else if (r_done0 | r_done1) begin
                r_busy <= 1'b0;
            end
            if (r_state == DONE) begin
                r_quotient <= w_sat ? '1 : r_num[Q_W-1:0];
                r_sat      <= w_sat;
                r_dz_o     <= r_dz;
            end
        end
    end
    assign bus.gnt0     = r_gnt0;
    assign bus.gnt1     = r_gnt1;
    assign bus.done0    = r_done0;
    assign bus.done1    = r_done1;
    assign bus.quotient = r_quotient;
    assign bus.sat      = r_sat;
    assign bus.dz       = r_dz_o;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scoreboard bench for div_arbiter (latency, saturation, divide-by-zero, abort, contention).
module tb_div_arbiter;
    localparam int NUM_W = 29;
    localparam int DEN_W = 17;
    localparam int Q_W   = 12;
    typedef struct {
        logic [Q_W-1:0] q;
        logic           s;
        logic           z;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    div_arbiter_if #(.NUM_W(NUM_W), .DEN_W(DEN_W), .Q_W(Q_W)) bus ();
    div_arbiter #(.NUM_W(NUM_W), .DEN_W(DEN_W), .Q_W(Q_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );
    function automatic exp_t model(input logic [NUM_W-1:0] n, input logic [DEN_W-1:0] d);
        exp_t   e;
        longint q;
        if (d == '0) begin
            e.q = '1; e.s = 1'b1; e.z = 1'b1;
        end else begin
            q   = longint'(n) / longint'(d);
            e.s = (q >= (longint'(1) << Q_W));
            e.q = e.s ? '1 : Q_W'(q);
            e.z = 1'b0;
        end
        return e;
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic wait_gnt(output bit who, output int gc);
        int n = 0;
        @(negedge clk);
        while (!(bus.gnt0 | bus.gnt1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("gnt_seen", 32'(bus.gnt0 | bus.gnt1), 1);
        check("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 0);
        check("busy_at_gnt", 32'(bus.busy), 1);
        who = bus.gnt1;
        gc  = cyc;
    endtask
    task automatic wait_done(input bit who, input int gc, input int lat);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!(bus.done0 | bus.done1) && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(bus.done0 | bus.done1), 1);
        check("done_who", 32'({bus.done1, bus.done0}), who ? 2 : 1);
        check("latency", 32'(cyc - gc), 32'(lat));
        check("busy_in_done", 32'(bus.busy), 1);
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '{q: '0, s: 1'b0, z: 1'b0};
        check("quotient", 32'(bus.quotient), 32'(e.q));
        check("sat", 32'(bus.sat), 32'(e.s));
        check("dz", 32'(bus.dz), 32'(e.z));
    endtask
    task automatic do_op(input bit who, input logic [NUM_W-1:0] num, input logic [DEN_W-1:0] den,
                         input int lat, input bit chg);
        bit w;
        int gc, c0;
        sb.push_back(model(num, den));
        if (who) begin
            bus.req1 = 1'b1; bus.num1 = num; bus.den1 = den;
        end else begin
            bus.req0 = 1'b1; bus.num0 = num; bus.den0 = den;
        end
        c0 = cyc;
        wait_gnt(w, gc);
        check("gnt_who", 32'(w), 32'(who));
        check("gnt_lat", 32'(gc - c0), 1);
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (chg) bus.num0 = '0;
        wait_done(who, gc, lat);
        @(negedge clk);
        check("done_pulse", 32'(bus.done0 | bus.done1), 0);
        check("busy_drop", 32'(bus.busy), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
    initial begin
        bit   w;
        int   gc, pg, seen;
        bit   ord[4];
        reset_n  = 1'b0;
        bus.req0 = 1'b0; bus.num0 = '0; bus.den0 = '0;
        bus.req1 = 1'b0; bus.num1 = '0; bus.den1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
        check("rst_done", 32'({bus.done0, bus.done1}), 0);
        check("rst_quotient", 32'(bus.quotient), 0);
        check("rst_flags", 32'({bus.sat, bus.dz, bus.busy}), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_op(1'b0, 29'd409500, 17'd100, 30, 1'b0);
        do_op(1'b1, 29'd8192000, 17'd1000, 30, 1'b0);
        do_op(1'b0, 29'd5, 17'd0, 1, 1'b0);
        do_op(1'b0, 29'd409500, 17'd100, 30, 1'b1);
        bus.req1 = 1'b1; bus.num1 = 29'd1200; bus.den1 = 17'd3;
        wait_gnt(w, gc);
        check("abort_gnt_who", 32'(w), 1);
        @(posedge clk);
        #1 bus.req1 = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_outputs", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.sat, bus.dz, bus.busy}), 0);
        check("abort_quotient", 32'(bus.quotient), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done0 | bus.done1 | bus.busy) seen++;
        end
        check("abort_no_done", 32'(seen), 0);
        do_op(1'b1, 29'd1200, 17'd3, 30, 1'b0);
`ifdef DIV_ARB_ROUND_ROBIN_EN
        ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        bus.num0 = 29'd1000; bus.den0 = 17'd10;
        bus.num1 = 29'd900;  bus.den1 = 17'd30;
        for (int i = 0; i < 4; i++) sb.push_back(ord[i] ? model(29'd900, 17'd30) : model(29'd1000, 17'd10));
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        pg = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(w, gc);
            check("cont_order", 32'(w), 32'(ord[i]));
            if (i > 0) check("cont_period", 32'(gc - pg), 31);
            pg = gc;
            wait_done(ord[i], gc, 30);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        check("cont_no_extra_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
        check("cont_idle", 32'(bus.busy), 0);
        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
